// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin issue arbiter for a shared fixed-latency ALU
// Registers the granted op into the ALU and tracks its tag through a latency-matched shadow pipe.
module alu_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TAG_WIDTH    = 6,
  parameter int DATA_LEN     = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int EX_LATENCY   = 2,
  localparam int CNT_W       = $clog2(EX_LATENCY + 2),
  localparam int PTR_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*ALU_OP_WIDTH-1:0] req_op_i,
  input  logic [NUM_REQ*DATA_LEN-1:0]     req_src1_i,
  input  logic [NUM_REQ*DATA_LEN-1:0]     req_src2_i,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_rrftag_i,
  input  logic [NUM_REQ-1:0]              req_wrrrf_i,
  output logic [NUM_REQ-1:0]              grant_o,
  input  logic                            stall_i,
  input  logic                            flush_i,
  output logic                            alu_issue_o,
  output logic [ALU_OP_WIDTH-1:0]         alu_op_o,
  output logic [DATA_LEN-1:0]             alu_src1_o,
  output logic [DATA_LEN-1:0]             alu_src2_o,
  output logic                            alu_wrrrf_o,
  input  logic [DATA_LEN-1:0]             alu_result_i,
  input  logic                            alu_rob_we_i,
  input  logic                            alu_rrf_we_i,
  output logic                            wb_valid_o,
  output logic [TAG_WIDTH-1:0]            wb_rrftag_o,
  output logic [DATA_LEN-1:0]             wb_result_o,
  output logic                            wb_rrf_we_o,
  output logic [CNT_W-1:0]                inflight_cnt_o,
  output logic                            err_o
);

  localparam int FW_W = $clog2(EX_LATENCY + 1);

  logic [PTR_W-1:0]        r_ptr;
  logic                    r_issue;
  logic [ALU_OP_WIDTH-1:0] r_op;
  logic [DATA_LEN-1:0]     r_src1;
  logic [DATA_LEN-1:0]     r_src2;
  logic                    r_wrrrf;
  logic [TAG_WIDTH-1:0]    r_issue_tag;
  logic [EX_LATENCY-1:0]   r_sh_v;
  logic [TAG_WIDTH-1:0]    r_sh_tag [EX_LATENCY];
  logic [FW_W-1:0]         r_flush_win;
  logic                    r_err;

  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_gnt_any;
  logic [PTR_W-1:0]        w_gnt_idx;
  logic [PTR_W:0]          w_sum;
  logic [PTR_W-1:0]        w_ptr_nxt;
  logic                    w_head_v;
  logic                    w_wb_valid;
  logic                    w_err_set;
  logic [CNT_W-1:0]        w_cnt;

  // Search starts at the pointer and wraps; the first ready requester wins.
  always_comb begin
    w_grant   = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    if (!(stall_i || flush_i || reset_i)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
        if (w_sum >= (PTR_W+1)'(NUM_REQ)) w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
        if (!w_gnt_any && req_valid_i[w_sum[PTR_W-1:0]]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_sum[PTR_W-1:0];
        end
      end
    end
    w_grant[w_gnt_idx] = w_gnt_any;
  end

  assign w_ptr_nxt = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr       <= '0;
      r_issue     <= 1'b0;
      r_op        <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_wrrrf     <= 1'b0;
      r_issue_tag <= '0;
    end else begin
      r_issue <= w_gnt_any;
      if (w_gnt_any) begin
        r_ptr       <= w_ptr_nxt;
        r_op        <= req_op_i[w_gnt_idx*ALU_OP_WIDTH +: ALU_OP_WIDTH];
        r_src1      <= req_src1_i[w_gnt_idx*DATA_LEN +: DATA_LEN];
        r_src2      <= req_src2_i[w_gnt_idx*DATA_LEN +: DATA_LEN];
        r_wrrrf     <= req_wrrrf_i[w_gnt_idx];
        r_issue_tag <= req_rrftag_i[w_gnt_idx*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Shadow pipe head lines up with the ALU result outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sh_v <= '0;
      for (int k = 0; k < EX_LATENCY; k++) r_sh_tag[k] <= '0;
    end else begin
      if (flush_i) begin
        r_sh_v <= '0;
      end else begin
        r_sh_v[0] <= r_issue;
        for (int k = 1; k < EX_LATENCY; k++) r_sh_v[k] <= r_sh_v[k-1];
      end
      r_sh_tag[0] <= r_issue_tag;
      for (int k = 1; k < EX_LATENCY; k++) r_sh_tag[k] <= r_sh_tag[k-1];
    end
  end

  assign w_head_v   = r_sh_v[EX_LATENCY-1];
  assign w_wb_valid = w_head_v & ~flush_i & ~reset_i;

  // Killed ops may still drain out of the ALU for EX_LATENCY cycles after a flush.
  assign w_err_set = (~w_head_v & alu_rob_we_i & ~flush_i & (r_flush_win == '0))
                   | (w_head_v & ~alu_rob_we_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_flush_win <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= r_err | w_err_set;
      if (flush_i) r_flush_win <= FW_W'(EX_LATENCY);
      else if (r_flush_win != '0) r_flush_win <= r_flush_win - 1'b1;
    end
  end

  always_comb begin
    w_cnt = CNT_W'(r_issue);
    for (int k = 0; k < EX_LATENCY; k++) w_cnt = w_cnt + CNT_W'(r_sh_v[k]);
  end

  assign grant_o        = w_grant;
  assign alu_issue_o    = r_issue;
  assign alu_op_o       = r_op;
  assign alu_src1_o     = r_src1;
  assign alu_src2_o     = r_src2;
  assign alu_wrrrf_o    = r_wrrrf;
  assign wb_valid_o     = w_wb_valid;
  assign wb_rrftag_o    = r_sh_tag[EX_LATENCY-1];
  assign wb_result_o    = alu_result_i;
  assign wb_rrf_we_o    = w_wb_valid & alu_rrf_we_i;
  assign inflight_cnt_o = w_cnt;
  assign err_o          = r_err;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - randomized bench for alu_issue_arbiter against a cycle-indexed model
// The bench also plays the ALU, returning results EX_LATENCY cycles after each issue.
module tb_alu_issue_arbiter;

  localparam int N    = 4;
  localparam int TW   = 6;
  localparam int DW   = 32;
  localparam int OW   = 4;
  localparam int L    = 2;
  localparam int CW   = $clog2(L + 2);
  localparam int MAXC = 4096;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_valid_i;
  logic [N*OW-1:0] req_op_i;
  logic [N*DW-1:0] req_src1_i;
  logic [N*DW-1:0] req_src2_i;
  logic [N*TW-1:0] req_rrftag_i;
  logic [N-1:0]    req_wrrrf_i;
  logic [N-1:0]    grant_o;
  logic            stall_i;
  logic            flush_i;
  logic            alu_issue_o;
  logic [OW-1:0]   alu_op_o;
  logic [DW-1:0]   alu_src1_o;
  logic [DW-1:0]   alu_src2_o;
  logic            alu_wrrrf_o;
  logic [DW-1:0]   alu_result_i;
  logic            alu_rob_we_i;
  logic            alu_rrf_we_i;
  logic            wb_valid_o;
  logic [TW-1:0]   wb_rrftag_o;
  logic [DW-1:0]   wb_result_o;
  logic            wb_rrf_we_o;
  logic [CW-1:0]   inflight_cnt_o;
  logic            err_o;

  alu_issue_arbiter #(
    .NUM_REQ(N), .TAG_WIDTH(TW), .DATA_LEN(DW), .ALU_OP_WIDTH(OW), .EX_LATENCY(L)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_src1_i(req_src1_i),
    .req_src2_i(req_src2_i), .req_rrftag_i(req_rrftag_i), .req_wrrrf_i(req_wrrrf_i),
    .grant_o(grant_o), .stall_i(stall_i), .flush_i(flush_i),
    .alu_issue_o(alu_issue_o), .alu_op_o(alu_op_o), .alu_src1_o(alu_src1_o),
    .alu_src2_o(alu_src2_o), .alu_wrrrf_o(alu_wrrrf_o),
    .alu_result_i(alu_result_i), .alu_rob_we_i(alu_rob_we_i), .alu_rrf_we_i(alu_rrf_we_i),
    .wb_valid_o(wb_valid_o), .wb_rrftag_o(wb_rrftag_o), .wb_result_o(wb_result_o),
    .wb_rrf_we_o(wb_rrf_we_o), .inflight_cnt_o(inflight_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int            t;
  int            ptr;
  int            lf;
  bit            force_rob;
  bit            m_issue;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a;
  logic [DW-1:0] m_b;
  bit            m_we;
  bit            m_err;

  logic [OW-1:0] p_op  [N];
  logic [DW-1:0] p_a   [N];
  logic [DW-1:0] p_b   [N];
  logic [TW-1:0] p_tag [N];
  bit            p_we  [N];

  // Expected writebacks (killed by flush/reset) and raw ALU returns, indexed by cycle.
  bit            lv   [MAXC];
  logic [TW-1:0] ltag [MAXC];
  logic [DW-1:0] lres [MAXC];
  bit            lwe  [MAXC];
  bit            sv   [MAXC];
  logic [DW-1:0] sres [MAXC];
  bit            swe  [MAXC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  task automatic new_pay(input int i);
    p_op[i]  = OW'($urandom_range(0, 5));
    p_a[i]   = $urandom;
    p_b[i]   = $urandom;
    p_tag[i] = TW'($urandom);
    p_we[i]  = 1'($urandom);
  endtask

  task automatic step(input logic [N-1:0] v, input logic s, input logic f, input logic r);
    int            g;
    int            cnt;
    int            j;
    int            wb;
    bit            hv;
    bit            wv;
    logic [N-1:0]  eg;
    req_valid_i = v;
    stall_i     = s;
    flush_i     = f;
    reset_i     = r;
    for (int i = 0; i < N; i++) begin
      req_op_i[i*OW +: OW]     = p_op[i];
      req_src1_i[i*DW +: DW]   = p_a[i];
      req_src2_i[i*DW +: DW]   = p_b[i];
      req_rrftag_i[i*TW +: TW] = p_tag[i];
      req_wrrrf_i[i]           = p_we[i];
    end
    alu_rob_we_i = sv[t] | force_rob;
    alu_rrf_we_i = sv[t] & swe[t];
    alu_result_i = sv[t] ? sres[t] : $urandom;

    @(negedge clk);
    g = -1;
    if (!(s || f || r)) begin
      for (int k = 0; k < N; k++) begin
        j = (ptr + k) % N;
        if (g < 0 && v[j]) g = j;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    hv = lv[t];
    wv = hv && !f && !r;
    check("grant", grant_o, eg);
    check("wb_valid", wb_valid_o, wv);
    check("wb_rrf_we", wb_rrf_we_o, wv && lwe[t]);
    if (wv) begin
      check("wb_tag", wb_rrftag_o, ltag[t]);
      check("wb_result", wb_result_o, lres[t]);
    end
    check("alu_issue", alu_issue_o, m_issue);
    check("alu_op", alu_op_o, m_op);
    check("alu_src1", alu_src1_o, m_a);
    check("alu_src2", alu_src2_o, m_b);
    check("alu_wrrrf", alu_wrrrf_o, m_we);
    cnt = 0;
    for (int d = 0; d <= L; d++) cnt += int'(lv[t+d]);
    check("inflight", inflight_cnt_o, cnt);
    check("err", err_o, m_err);

    if (r) begin
      ptr = 0; m_issue = 0; m_op = '0; m_a = '0; m_b = '0; m_we = 0; m_err = 0; lf = -100;
      for (int d = 0; d <= L + 1; d++) begin
        lv[t+d] = 0;
        sv[t+d+1] = 0;
      end
    end else begin
      if ((!hv && alu_rob_we_i && !f && (t - lf > L)) || (hv && !alu_rob_we_i)) m_err = 1;
      if (f) begin
        for (int d = 0; d <= L + 1; d++) lv[t+d] = 0;
        lf = t;
      end
      if (g >= 0) begin
        ptr = (g + 1) % N;
        m_issue = 1; m_op = p_op[g]; m_a = p_a[g]; m_b = p_b[g]; m_we = p_we[g];
        wb = t + 1 + L;
        lv[wb] = 1; ltag[wb] = p_tag[g]; lres[wb] = alu_fn(p_op[g], p_a[g], p_b[g]); lwe[wb] = p_we[g];
        sv[wb] = 1; sres[wb] = lres[wb]; swe[wb] = p_we[g];
        new_pay(g);
      end else begin
        m_issue = 0;
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cycle=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    t = 0; ptr = 0; lf = -100; force_rob = 0;
    m_issue = 0; m_op = '0; m_a = '0; m_b = '0; m_we = 0; m_err = 0;
    for (int i = 0; i < N; i++) new_pay(i);
    reset_i = 1; stall_i = 0; flush_i = 0; req_valid_i = '0;
    req_op_i = '0; req_src1_i = '0; req_src2_i = '0; req_rrftag_i = '0; req_wrrrf_i = '0;
    alu_result_i = '0; alu_rob_we_i = 0; alu_rrf_we_i = 0;
    @(posedge clk);
    #1;
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);

    p_op[0] = 4'd0; p_a[0] = 32'd5; p_b[0] = 32'd7; p_tag[0] = 6'h0A; p_we[0] = 1;
    step(4'b0001, 0, 0, 0);
    repeat (4) step('0, 0, 0, 0);

    repeat (8) step(4'b1111, 0, 0, 0);
    repeat (4) step('0, 0, 0, 0);

    step('0, 0, 0, 1);
    repeat (3) step(4'b1010, 0, 0, 0);
    repeat (4) step('0, 0, 0, 0);

    for (int k = 1; k <= 3; k++) begin
      p_tag[0] = TW'(k);
      step(4'b0001, 0, 0, 0);
    end
    step(4'b0001, 0, 1, 0);
    repeat (4) step('0, 0, 0, 0);

    repeat (3) step(4'b0100, 1, 0, 0);
    step(4'b0100, 0, 0, 0);
    step(4'b1111, 1, 1, 0);
    repeat (4) step('0, 0, 0, 0);

    step(4'b0011, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    step('0, 0, 0, 1);
    repeat (4) step('0, 0, 0, 0);
    force_rob = 1;
    step('0, 0, 0, 0);
    force_rob = 0;
    repeat (4) step('0, 0, 0, 0);
    step('0, 0, 0, 1);
    repeat (2) step('0, 0, 0, 0);

    repeat (1200) begin
      step(N'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
    end
    repeat (L + 2) step('0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
